// File: rtl/sgmii_rx_sync_ctl.sv
// SGMII receive word-sync controller: bit-slips the symbol gearbox until commas align,
// qualifies lock on clean commas and tracks error density. Define SGMII_SYNC_STATS_EN for live stats counters.
module sgmii_rx_sync_ctl #(
  parameter int SLIP_WINDOW  = 20,
  parameter int SLIP_HOLDOFF = 4,
  parameter int ACQ_COMMAS   = 3,
  parameter int ERR_LIMIT    = 4,
  parameter int GOOD_RUN     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        symbol_valid,
  input  logic        symbol_is_comma,
  input  logic        symbol_err,
  input  logic        disparity_err,
  input  logic        force_resync,
  output logic        bitslip,
  output logic        locked,
  output logic [1:0]  sync_state,
  output logic [15:0] slip_count,
  output logic [15:0] lol_count
);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_WAIT = 2'd1,
    ACQUIRE   = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  localparam logic [7:0] WIN  = 8'(SLIP_WINDOW);
  localparam logic [3:0] HOLD = 4'(SLIP_HOLDOFF);
  localparam logic [3:0] ACQ  = 4'(ACQ_COMMAS);
  localparam logic [3:0] LIM  = 4'(ERR_LIMIT);
  localparam logic [3:0] RUN  = 4'(GOOD_RUN);

  function automatic logic [7:0] inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  function automatic logic [3:0] inc4(input logic [3:0] x);
    return (x == 4'hF) ? x : x + 4'd1;
  endfunction

  state_t     state, state_nx;
  logic [7:0] sym_cnt, sym_cnt_nx;
  logic [3:0] hold_cnt, hold_cnt_nx;
  logic [3:0] comma_cnt, comma_cnt_nx;
  logic [3:0] bucket, bucket_nx;
  logic [3:0] good_cnt, good_cnt_nx;
  logic       slip_nx;
  logic       bitslip_q;

  logic serr, clean, comma_ok;
  assign serr     = symbol_valid & (symbol_err | disparity_err);
  assign clean    = symbol_valid & ~serr;
  assign comma_ok = clean & symbol_is_comma;

  always_comb begin
    state_nx     = state;
    sym_cnt_nx   = sym_cnt;
    hold_cnt_nx  = hold_cnt;
    comma_cnt_nx = comma_cnt;
    bucket_nx    = bucket;
    good_cnt_nx  = good_cnt;
    slip_nx      = 1'b0;
    if (force_resync) begin
      state_nx     = HUNT;
      sym_cnt_nx   = '0;
      hold_cnt_nx  = '0;
      comma_cnt_nx = '0;
      bucket_nx    = '0;
      good_cnt_nx  = '0;
    end else if (symbol_valid) begin
      unique case (state)
        HUNT: begin
          if (comma_ok) begin
            sym_cnt_nx   = '0;
            comma_cnt_nx = 4'd1;
            if (ACQ == 4'd1) begin
              state_nx     = LOCKED;
              comma_cnt_nx = '0;
              bucket_nx    = '0;
              good_cnt_nx  = '0;
            end else begin
              state_nx = ACQUIRE;
            end
          end else if (inc8(sym_cnt) == WIN) begin
            slip_nx     = 1'b1;
            state_nx    = SLIP_WAIT;
            sym_cnt_nx  = '0;
            hold_cnt_nx = '0;
          end else begin
            sym_cnt_nx = inc8(sym_cnt);
          end
        end
        SLIP_WAIT: begin
          if (inc4(hold_cnt) == HOLD) begin
            state_nx    = HUNT;
            hold_cnt_nx = '0;
            sym_cnt_nx  = '0;
          end else begin
            hold_cnt_nx = inc4(hold_cnt);
          end
        end
        ACQUIRE: begin
          if (serr) begin
            state_nx     = HUNT;
            sym_cnt_nx   = '0;
            comma_cnt_nx = '0;
          end else if (symbol_is_comma) begin
            sym_cnt_nx = '0;
            if (inc4(comma_cnt) == ACQ) begin
              state_nx     = LOCKED;
              comma_cnt_nx = '0;
              bucket_nx    = '0;
              good_cnt_nx  = '0;
            end else begin
              comma_cnt_nx = inc4(comma_cnt);
            end
          end else if (inc8(sym_cnt) == WIN) begin
            // comma stream vanished before lock qualified; search again without slipping
            state_nx     = HUNT;
            sym_cnt_nx   = '0;
            comma_cnt_nx = '0;
          end else begin
            sym_cnt_nx = inc8(sym_cnt);
          end
        end
        LOCKED: begin
          if (serr) begin
            good_cnt_nx = '0;
            if (inc4(bucket) == LIM) begin
              state_nx  = HUNT;
              bucket_nx = '0;
            end else begin
              bucket_nx = inc4(bucket);
            end
          end else if (inc4(good_cnt) == RUN) begin
            good_cnt_nx = '0;
            if (bucket != 4'd0) bucket_nx = bucket - 4'd1;
          end else begin
            good_cnt_nx = inc4(good_cnt);
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sym_cnt   <= '0;
      hold_cnt  <= '0;
      comma_cnt <= '0;
      bucket    <= '0;
      good_cnt  <= '0;
      bitslip_q <= 1'b0;
    end else begin
      state     <= state_nx;
      sym_cnt   <= sym_cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      comma_cnt <= comma_cnt_nx;
      bucket    <= bucket_nx;
      good_cnt  <= good_cnt_nx;
      bitslip_q <= slip_nx;
    end
  end

  assign bitslip    = bitslip_q;
  assign locked     = (state == LOCKED);
  assign sync_state = state;

`ifdef SGMII_SYNC_STATS_EN
  logic [15:0] slip_cnt_q, lol_cnt_q;
  logic        lol_evt;

  // loss of lock: forced resync out of LOCKED, or the bucket filling up
  assign lol_evt = (state == LOCKED) &
                   (force_resync | (serr & (inc4(bucket) == LIM)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_cnt_q <= '0;
      lol_cnt_q  <= '0;
    end else begin
      if (slip_nx && slip_cnt_q != 16'hFFFF) slip_cnt_q <= slip_cnt_q + 16'd1;
      if (lol_evt && lol_cnt_q  != 16'hFFFF) lol_cnt_q  <= lol_cnt_q + 16'd1;
    end
  end

  assign slip_count = slip_cnt_q;
  assign lol_count  = lol_cnt_q;
`else
  assign slip_count = 16'd0;
  assign lol_count  = 16'd0;
`endif

endmodule

// File: doc/sgmii_rx_sync_ctl.md
# sgmii_rx_sync_ctl

Receive word-synchronisation controller for the oversampled SGMII receive path. It watches the per-symbol status from the 8b/10b decoder and sequences bit-slips of the 10-bit symbol gearbox until commas land on symbol boundaries. It then qualifies lock with a run of clean commas and monitors error density to declare loss of sync. It sits between the symbol gearbox/decoder and the PCS, and replaces ad-hoc bitslip logic inside the decoder.

## Interface
Parameters:
- SLIP_WINDOW, 20: symbols searched without a comma before a bit-slip is issued (2..255)
- SLIP_HOLDOFF, 4: valid symbols ignored after each bit-slip while the gearbox re-settles (1..15)
- ACQ_COMMAS, 3: consecutive error-free commas required to declare lock (1..15)
- ERR_LIMIT, 4: error-bucket level that declares loss of sync (1..15)
- GOOD_RUN, 4: consecutive clean symbols that drain the error bucket by one (1..15)

Ports:
- clk, in, 1: 312.5 MHz receive fabric clock
- rst_n, in, 1: asynchronous active-low reset
- symbol_valid, in, 1: decoder status below is valid this cycle
- symbol_is_comma, in, 1: symbol was K28.5
- symbol_err, in, 1: invalid 10b code
- disparity_err, in, 1: running-disparity violation
- force_resync, in, 1: one-cycle request to drop to HUNT
- bitslip, out, 1: one-cycle pulse; gearbox discards one bit
- locked, out, 1: word sync achieved
- sync_state, out, 2: 0=HUNT, 1=SLIP_WAIT, 2=ACQUIRE, 3=LOCKED
- slip_count, out, 16: saturating bit-slip counter (stats build only)
- lol_count, out, 16: saturating loss-of-lock counter (stats build only)

## Operation
- Symbol error (serr) = symbol_valid & (symbol_err | disparity_err). Status inputs are ignored when symbol_valid is low.
- HUNT:
  - Count valid symbols.
  - Comma without serr -> ACQUIRE with comma count = 1.
  - Count reaching SLIP_WINDOW -> pulse bitslip, go to SLIP_WAIT, reset the count.
- SLIP_WAIT: ignore SLIP_HOLDOFF valid symbols, then go to HUNT with the count cleared.
- ACQUIRE:
  - Any serr -> HUNT, no slip.
  - Error-free comma increments the comma count; reaching ACQ_COMMAS -> LOCKED with the bucket cleared.
  - SLIP_WINDOW valid symbols since the last comma without a new one -> HUNT.
- LOCKED:
  - Each serr adds 1 to the bucket and clears the good-run counter.
  - GOOD_RUN consecutive clean valid symbols decrement a non-zero bucket and restart the run.
  - Bucket reaching ERR_LIMIT -> HUNT and increment lol_count.
- force_resync moves to HUNT from any state and clears all counters.
  - It takes priority over every same-cycle event, and no bitslip pulse is emitted in that cycle.
  - From LOCKED it also increments lol_count.
- locked = (state == LOCKED).
- All internal counters saturate and never wrap.

## Timing
- Reset values: state HUNT, bitslip 0, locked 0, sync_state 0, slip_count 0, lol_count 0, all internal counters 0.
- All outputs are registered. A decision made on a valid symbol in cycle N is visible in cycle N+1.
- bitslip is high for exactly one clk cycle per slip. Back-to-back slips are separated by at least SLIP_HOLDOFF valid symbols.
- locked rises one cycle after the ACQ_COMMAS-th clean comma is sampled. It falls one cycle after the ERR_LIMIT-th bucket increment or after force_resync.
- Comma with serr in the same symbol: treated as an error only.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Deassertion is synchronised by the integrating logic.

## Configuration
- SGMII_SYNC_STATS_EN defined:
  - slip_count and lol_count are live 16-bit saturating counters, saturating at 16'hFFFF.
  - They are cleared only by rst_n.
- SGMII_SYNC_STATS_EN undefined:
  - Both ports remain present and are tied to 0.
  - No counter registers are synthesised.
  - All other behaviour is identical.

## Test plan
- Aligned stream with K28.5 every 10 symbols, no errors -> locked=1 one cycle after the 3rd comma; bitslip never pulses.
- Misaligned stream with no valid comma -> bitslip pulse after 20 valid symbols, then every 20+4 valid symbols; slip_count increments per pulse (stats build).
- LOCKED, inject 4 symbol_err spaced 2 clean symbols apart -> locked drops after the 4th error; lol_count=1.
- LOCKED, inject 1 error every 5 clean symbols -> the bucket never exceeds 1 and locked stays 1.
- ACQUIRE after 2 commas, disparity_err on the next symbol -> HUNT with no bitslip; locked stays 0.
- force_resync in the same cycle the bucket would hit ERR_LIMIT -> HUNT, no bitslip, lol_count +1 exactly once. Repeat with rst_n low mid-ACQUIRE -> all outputs 0 immediately.
